cache_tag: RTL and testbench

CACHE_TAG -- requirements
Module: cache_tag

---
 rtl/cache_tag_if.sv | 34 +++
 rtl/cache_tag.sv | 139 +++++++++++++
 tb/tb_cache_tag.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_tag_if.sv
// Request/response and line-fill signals of the cache tag block.
// The Flush line exists only when CACHE_FLUSH_EN is defined.
interface cache_tag_if;
    logic        Req;
    logic        WR;
    logic        CacheCS;
    logic [27:0] CA;
    logic        Ack;
    logic        Hit;
    logic        FillReq;
    logic        FillAck;
    logic        Ready;
`ifdef CACHE_FLUSH_EN
    logic        Flush;
`endif

    // Handshake: Req is held by the requester until a one-cycle Ack; Hit is
    // meaningful only while Ack is high. FillReq is held until FillAck.
    modport master (
`ifdef CACHE_FLUSH_EN
        output Flush,
`endif
        output Req, WR, CacheCS, CA, FillAck,
        input  Ack, Hit, FillReq, Ready
    );

    modport slave (
`ifdef CACHE_FLUSH_EN
        input  Flush,
`endif
        input  Req, WR, CacheCS, CA, FillAck,
        output Ack, Hit, FillReq, Ready
    );
endinterface

// File: rtl/cache_tag.sv
// Direct-mapped 256-entry tag store with read-allocate fills and write-through.
// Optional whole-cache invalidate through Flush when CACHE_FLUSH_EN is defined.
module cache_tag (
    input  logic        CLK,
    input  logic        nRES,
    cache_tag_if.slave  bus
);

    typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        hit_q, hit_d;
    logic        fillreq_q, fillreq_d;
    logic [23:0] ca_q, ca_d;   // latched CA[27:4]

    logic [255:0] valid_q;
    logic [15:0]  tag_q [256];

    logic        we;
    logic [7:0]  we_idx;
    logic [15:0] we_tag;
    logic        we_valid;

    logic [7:0]  lk_idx;
    logic        lk_hit;
    logic        flush_now;
    logic        unused_ca;

    assign unused_ca = ^bus.CA[3:0];
    assign lk_idx    = bus.CA[11:4];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == bus.CA[27:12]);

`ifdef CACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
    assign flush_now = bus.Flush || flush_pend_q;
`else
    assign flush_now = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        hit_d     = 1'b0;
        fillreq_d = fillreq_q;
        ca_d      = ca_q;
        we        = 1'b0;
        we_idx    = cnt_q;
        we_tag    = ca_q[23:8];
        we_valid  = 1'b0;
`ifdef CACHE_FLUSH_EN
        flush_pend_d = flush_pend_q;
`endif
        case (state_q)
            INIT: begin
                we    = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) state_d = IDLE;
            end
            IDLE: begin
                // Flush outranks Req; a Req left high is picked up after the sweep.
                if (flush_now) begin
                    state_d = INIT;
                    cnt_d   = 8'd0;
`ifdef CACHE_FLUSH_EN
                    flush_pend_d = 1'b0;
`endif
                end else if (bus.Req && !ack_q) begin
                    ca_d = bus.CA[27:4];
                    if (!bus.CacheCS) begin
                        ack_d = 1'b1;
                    end else if (bus.WR || lk_hit) begin
                        ack_d = 1'b1;
                        hit_d = lk_hit;
                    end else begin
                        state_d   = FILL;
                        fillreq_d = 1'b1;
                    end
                end
            end
            FILL: begin
`ifdef CACHE_FLUSH_EN
                flush_pend_d = flush_pend_q || bus.Flush;
`endif
                if (bus.FillAck) begin
                    we        = 1'b1;
                    we_idx    = ca_q[7:0];
                    we_valid  = 1'b1;
                    fillreq_d = 1'b0;
                    ack_d     = 1'b1;
                    hit_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state_q   <= INIT;
            cnt_q     <= 8'd0;
            ack_q     <= 1'b0;
            hit_q     <= 1'b0;
            fillreq_q <= 1'b0;
            ca_q      <= 24'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            hit_q     <= hit_d;
            fillreq_q <= fillreq_d;
            ca_q      <= ca_d;
        end
    end

`ifdef CACHE_FLUSH_EN
    always_ff @(posedge CLK) begin
        if (!nRES) flush_pend_q <= 1'b0;
        else       flush_pend_q <= flush_pend_d;
    end
`endif

    // Tag array has no reset; the INIT sweep clears every valid bit.
    always_ff @(posedge CLK) begin
        if (nRES && we) begin
            valid_q[we_idx] <= we_valid;
            tag_q[we_idx]   <= we_tag;
        end
    end

    assign bus.Ack     = ack_q;
    assign bus.Hit     = hit_q;
    assign bus.FillReq = fillreq_q;
    assign bus.Ready   = (state_q != INIT);

endmodule

// File: tb/tb_cache_tag.sv
// Directed bench for cache_tag: reset sweep, hit/miss/fill, write-through,
// uncached access, reset during fill, and Flush when CACHE_FLUSH_EN is set.
module tb_cache_tag;

  logic clk;
  logic nres;
  int   n_checks;
  int   n_errors;
  int   viol;
  logic prev_ack;

  cache_tag_if bus();

  cache_tag dut (
    .CLK  (clk),
    .nRES (nres),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ack must never repeat on consecutive cycles nor coincide with FillReq.
  always @(negedge clk) begin
    if (nres) begin
      if (bus.Ack && bus.FillReq) viol++;
      if (bus.Ack && prev_ack) viol++;
    end
    prev_ack = bus.Ack;
  end

  task automatic do_reset();
    int rdy0;
    int ack_seen;
    nres = 1'b0;
    bus.Req = 1'b0;
    bus.FillAck = 1'b0;
`ifdef CACHE_FLUSH_EN
    bus.Flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ack", bus.Ack, 0);
    check("rst_hit", bus.Hit, 0);
    check("rst_fillreq", bus.FillReq, 0);
    check("rst_ready", bus.Ready, 0);
    nres = 1'b1;
    rdy0 = 0;
    ack_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.Ack) ack_seen++;
      if (bus.Ready) break;
      rdy0++;
      @(negedge clk);
    end
    check("sweep_len", rdy0, 256);
    check("sweep_ack", ack_seen, 0);
  endtask

  task automatic access(input logic [27:0] ca, input logic wr, input logic cs,
                        input int fill_delay, input bit scramble,
                        output logic hit, output int lat, output int fr);
    @(negedge clk);
    bus.CA = ca;
    bus.WR = wr;
    bus.CacheCS = cs;
    bus.Req = 1'b1;
    hit = 1'b0;
    lat = 0;
    fr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.Ack) begin
        hit = bus.Hit;
        break;
      end
      if (bus.FillReq) begin
        fr++;
        if (scramble) begin
          bus.CA = 28'h0009990;
          bus.WR = 1'b1;
          bus.CacheCS = 1'b0;
        end
        if (fr >= fill_delay) bus.FillAck = 1'b1;
      end
    end
    check("ack_seen", bus.Ack, 1);
    bus.Req = 1'b0;
    bus.FillAck = 1'b0;
  endtask

  logic h;
  int   lat;
  int   fr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    viol = 0;
    prev_ack = 1'b0;
    nres = 1'b0;
    bus.Req = 1'b0;
    bus.WR = 1'b0;
    bus.CacheCS = 1'b0;
    bus.CA = 28'd0;
    bus.FillAck = 1'b0;
`ifdef CACHE_FLUSH_EN
    bus.Flush = 1'b0;
`endif

    do_reset();

    // Cold miss with a 3-cycle fill, then hit.
    access(28'h0001230, 1'b0, 1'b1, 3, 1'b0, h, lat, fr);
    check("a_fr", fr, 3);  check("a_hit", h, 1);  check("a_lat", lat, 4);
    access(28'h0001230, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("b_fr", fr, 0);  check("b_hit", h, 1);  check("b_lat", lat, 1);

    // Same index, different tag: replaces the line.
    access(28'h0011230, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("c_fr", fr, 1);  check("c_hit", h, 1);  check("c_lat", lat, 2);
    access(28'h0001230, 1'b0, 1'b1, 2, 1'b0, h, lat, fr);
    check("d_fr", fr, 2);  check("d_lat", lat, 3);

    // Write miss does not allocate; write hit reports Hit.
    access(28'h0002000, 1'b1, 1'b1, 1, 1'b0, h, lat, fr);
    check("e_fr", fr, 0);  check("e_hit", h, 0);  check("e_lat", lat, 1);
    access(28'h0002000, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("f_fr", fr, 1);
    access(28'h0002000, 1'b1, 1'b1, 1, 1'b0, h, lat, fr);
    check("g_hit", h, 1);  check("g_lat", lat, 1);  check("g_fr", fr, 0);

    // Uncached access.
    access(28'h0001230, 1'b0, 1'b0, 1, 1'b0, h, lat, fr);
    check("h_hit", h, 0);  check("h_fr", fr, 0);  check("h_lat", lat, 1);
    access(28'h0001230, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("h2_hit", h, 1);  check("h2_lat", lat, 1);

    // Inputs changed mid-fill must not affect the filled line.
    access(28'h0003450, 1'b0, 1'b1, 2, 1'b1, h, lat, fr);
    check("i_fr", fr, 2);  check("i_hit", h, 1);
    access(28'h0003450, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("i2_lat", lat, 1);  check("i2_fr", fr, 0);
    access(28'h0009990, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("i3_fr", fr, 1);

    // Stray FillAck in IDLE is ignored.
    @(negedge clk);
    bus.FillAck = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("j_ack", bus.Ack, 0);
      check("j_fillreq", bus.FillReq, 0);
    end
    bus.FillAck = 1'b0;
    access(28'h0004560, 1'b0, 1'b1, 2, 1'b0, h, lat, fr);
    check("j_fr", fr, 2);  check("j_lat", lat, 3);

    // Reset during FILL.
    @(negedge clk);
    bus.CA = 28'h0005670;
    bus.WR = 1'b0;
    bus.CacheCS = 1'b1;
    bus.Req = 1'b1;
    fr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.FillReq) begin
        fr = 1;
        break;
      end
    end
    check("k_fillreq_up", fr, 1);
    nres = 1'b0;
    bus.Req = 1'b0;
    @(negedge clk);
    check("k_fillreq_drop", bus.FillReq, 0);
    check("k_ack", bus.Ack, 0);
    do_reset();
    access(28'h0004560, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
    check("k_swept_fr", fr, 1);

`ifdef CACHE_FLUSH_EN
    begin
      int rdy0;
      access(28'h0001230, 1'b0, 1'b1, 1, 1'b0, h, lat, fr);
      @(negedge clk);
      bus.CA = 28'h0001230;
      bus.WR = 1'b0;
      bus.CacheCS = 1'b1;
      bus.Req = 1'b1;
      bus.Flush = 1'b1;
      rdy0 = 0;
      fr = 0;
      h = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        bus.Flush = 1'b0;
        if (bus.Ack) begin
          h = bus.Hit;
          break;
        end
        if (!bus.Ready) rdy0++;
        if (bus.FillReq) begin
          fr++;
          bus.FillAck = 1'b1;
        end
      end
      check("fl_ack", bus.Ack, 1);
      bus.Req = 1'b0;
      bus.FillAck = 1'b0;
      check("fl_sweep", rdy0, 256);
      check("fl_miss_fr", fr, 1);
      check("fl_hit", h, 1);

      // Flush during FILL is deferred until after the Ack cycle.
      @(negedge clk);
      bus.CA = 28'h0007770;
      bus.Req = 1'b1;
      fr = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        bus.Flush = 1'b0;
        if (bus.Ack) break;
        if (bus.FillReq) begin
          fr++;
          if (fr == 1) bus.Flush = 1'b1;
          if (fr >= 3) bus.FillAck = 1'b1;
        end
      end
      check("fp_ack", bus.Ack, 1);
      check("fp_fr", fr, 3);
      bus.Req = 1'b0;
      bus.FillAck = 1'b0;
      @(negedge clk);
      check("fp_ready_drop", bus.Ready, 0);
      for (int i = 0; i < 400; i++) begin
        if (bus.Ready) break;
        @(negedge clk);
      end
      check("fp_ready_back", bus.Ready, 1);
    end
`endif

    repeat (2) @(negedge clk);
    check("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
